// File: rtl/inv_sub_bytes_seq.sv
// Purpose     : iterative AES InvSubBytes engine; one byte per 8 cycles, S-box computed arithmetically.
// Latency     : out_valid rises on the 8*NBYTES-th edge after the accept edge (128 for NBYTES=16).
// Backpressure: holds the result with in_ready low until out_ready; the next accept is one cycle after handoff.
//
// Ports:
//   clk, rst            - single rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   - input state handshake; in_data byte 0 is the most significant byte
//   out_valid/out_ready - result handshake; out_data uses the same byte positions as in_data
//   fwd_mode            - only with SUBBYTES_FWD_EN defined: 1 = forward SubBytes, 0 = InvSubBytes
//
// Optional build macro: SUBBYTES_FWD_EN adds the fwd_mode port and the forward S-box path.
module inv_sub_bytes_seq #(
    parameter int         NBYTES = 16,
    parameter logic [7:0] POLY   = 8'h1B
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_data,
`ifdef SUBBYTES_FWD_EN
    input  logic                  fwd_mode,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_data
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EXP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Carry-less multiply with interleaved reduction by x^8 + POLY.
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? POLY : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

`ifdef SUBBYTES_FWD_EN
    function automatic logic [7:0] fwd_affine(input logic [7:0] v);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction
`endif

    logic [1:0]            r_state;
    logic [IW-1:0]         r_idx;
    logic [2:0]            r_step;
    logic [8*NBYTES-1:0]   r_in;
    logic [8*NBYTES-1:0]   r_out;
    logic [7:0]            r_x;
    logic [7:0]            r_r;
    logic                  r_out_valid;
`ifdef SUBBYTES_FWD_EN
    logic                  r_fwd;
`endif

    logic [7:0]            w_byte;
    logic [7:0]            w_inv_aff;
    logic [7:0]            w_sq;
    logic [7:0]            w_sqmul;
    logic [7:0]            w_load;
    logic [7:0]            w_res;

    // Select the current input byte; byte 0 sits in the top bits.
    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IW'(i)) w_byte = r_in[8*(NBYTES-1-i) +: 8];
        end
    end

    // Inverse affine maps the S-box output back to the field inverse's argument.
    assign w_inv_aff = rotl(w_byte, 1) ^ rotl(w_byte, 3) ^ rotl(w_byte, 6) ^ 8'h05;

    // One square-and-multiply step: r^2 * x. Six of these plus a final square give x^254.
    assign w_sq    = gfmul(r_r, r_r);
    assign w_sqmul = gfmul(w_sq, r_x);

`ifdef SUBBYTES_FWD_EN
    assign w_load = r_fwd ? w_byte : w_inv_aff;
    assign w_res  = r_fwd ? fwd_affine(w_sq) : w_sq;
`else
    assign w_load = w_inv_aff;
    assign w_res  = w_sq;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_step      <= 3'd0;
            r_in        <= '0;
            r_out       <= '0;
            r_x         <= 8'h00;
            r_r         <= 8'h00;
            r_out_valid <= 1'b0;
`ifdef SUBBYTES_FWD_EN
            r_fwd       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in    <= in_data;
                        r_idx   <= '0;
`ifdef SUBBYTES_FWD_EN
                        r_fwd   <= fwd_mode;
`endif
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_x     <= w_load;
                    r_r     <= w_load;
                    r_step  <= 3'd0;
                    r_state <= S_EXP;
                end
                S_EXP: begin
                    if (r_step != 3'd6) begin
                        r_r    <= w_sqmul;
                        r_step <= r_step + 3'd1;
                    end else begin
                        r_r <= w_sq;
                        for (int i = 0; i < NBYTES; i++) begin
                            if (r_idx == IW'(i)) r_out[8*(NBYTES-1-i) +: 8] <= w_res;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    // S_DONE: result held until downstream takes it.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;

    localparam int NB = 16;
    localparam int W  = 8 * NB;
    localparam int LAT = 8 * NB;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
`ifdef SUBBYTES_FWD_EN
    logic           fwd_mode;
`endif

    inv_sub_bytes_seq #(.NBYTES(NB), .POLY(8'h1B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SUBBYTES_FWD_EN
        .fwd_mode  (fwd_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0] sb[256];
    logic [7:0] isb[256];

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bounded wait expired", nm);
    endtask

    // Reference model: schoolbook product reduced by 0x11B, inverse by exhaustive search.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_aff(input logic [7:0] v);
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic build_model();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = m_aff(inv);
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    // Drive one state, push its expected result; in_data is scrambled after accept.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] req);
        int n;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) fail_now("accept_wait");
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        acc_cyc  = cyc;
        exp_q.push_back(req);
    endtask

    task automatic collect(input string nm, output logic [W-1:0] got);
        int n;
        logic [W-1:0] req;
        n = 0;
        got = '0;
        while (!out_valid && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid) begin
            fail_now({nm, "_out_wait"});
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            chk({nm, "_latency"}, W'(cyc - acc_cyc), W'(LAT));
            got = out_data;
            if (exp_q.size() == 0) fail_now({nm, "_queue_empty"});
            else begin
                req = exp_q.pop_front();
                chk({nm, "_data"}, out_data, req);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] din;
        logic [W-1:0] req;
        logic [W-1:0] rec;
        bit saw;
        int prev_acc;

        tbl[0].din  = 128'h637c1652ed00_63636363636363636363;
        tbl[0].dout = 128'h0001ff485352_00000000000000000000;
        tbl[1].din  = {16{8'h00}};
        tbl[1].dout = {16{8'h52}};
        tbl[2].din  = {16{8'hff}};
        tbl[2].dout = {16{8'h7d}};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef SUBBYTES_FWD_EN
        fwd_mode = 1'b0;
`endif
        build_model();

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", W'(in_ready), W'(1));
        chk("idle_out_valid", W'(out_valid), W'(0));

        // Table vectors with out_ready high: one-cycle handoff, back to IDLE
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            send(tbl[t].din, tbl[t].dout);
            collect($sformatf("tbl%0d", t), got);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid_drop", t), W'(out_valid), W'(0));
            chk($sformatf("tbl%0d_idle", t), W'(in_ready), W'(1));
        end

        // Backpressure: result held 20 cycles, competing input ignored
        out_ready = 1'b0;
        send(tbl[0].din, tbl[0].dout);
        collect("bp", got);
        in_valid = 1'b1;
        in_data  = tbl[1].din;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", i), W'(out_valid), W'(1));
            chk($sformatf("bp_data_%0d", i), out_data, tbl[0].dout);
            chk($sformatf("bp_in_ready_%0d", i), W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handoff_valid", W'(out_valid), W'(0));
        chk("bp_handoff_in_ready", W'(in_ready), W'(1));
        chk("bp_data_held", out_data, tbl[0].dout);

        // Reset in the middle of an operation
        send(tbl[2].din, tbl[2].dout);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        chk("mid_rst_data", out_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        chk("mid_rst_no_output", W'(saw), W'(0));
        send(tbl[0].din, tbl[0].dout);
        collect("post_rst", got);
        @(posedge clk); #1;

        // All 256 byte values over 16 back-to-back states, checked against the model
        prev_acc = 0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < NB; j++) begin
                din[8*(NB-1-j) +: 8] = 8'(16*k + j);
                req[8*(NB-1-j) +: 8] = isb[8'(16*k + j)];
            end
            send(din, req);
            if (k > 0) chk($sformatf("exh%0d_period", k), W'(acc_cyc - prev_acc), W'(LAT + 2));
            prev_acc = acc_cyc;
            collect($sformatf("exh%0d", k), got);
            for (int j = 0; j < NB; j++) rec[8*(NB-1-j) +: 8] = sb[got[8*(NB-1-j) +: 8]];
            chk($sformatf("exh%0d_roundtrip", k), rec, din);
            @(posedge clk); #1;
        end

`ifdef SUBBYTES_FWD_EN
        // Forward mode, then the same input in inverse mode; mode flips after accept are ignored
        fwd_mode = 1'b1;
        send(128'h000153ff_000000000000000000000000, 128'h637ced16_636363636363636363636363);
        fwd_mode = 1'b0;
        collect("fwd1", got);
        @(posedge clk); #1;
        fwd_mode = 1'b0;
        send(128'h000153ff_000000000000000000000000, 128'h5209507d_525252525252525252525252);
        fwd_mode = 1'b1;
        collect("fwd0", got);
        @(posedge clk); #1;
        fwd_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
